i2s_sample_fifo: RTL and testbench

I2S_SAMPLE_FIFO -- requirements
Module: i2s_sample_fifo

---
 rtl/i2s_sample_fifo.sv | 163 ++++++++++++++++
 tb/tb_i2s_sample_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_sample_fifo.sv
// i2s_sample_fifo: captures one stereo pair per I2S frame, a fixed number of
// sclk cycles after the right word ends, into a first-word fall-through FIFO.
// Optional feature: define I2S_FIFO_OVF_CNT_EN to add the saturating
// ovf_count dropped-frame counter port.
module i2s_sample_fifo #(
   parameter int WIDTH     = 16,
   parameter int DEPTH     = 8,
   parameter int CAP_DELAY = 2
) (
   input  logic                     sclk,
   input  logic                     rst,
   input  logic                     ws,
   input  logic [WIDTH-1:0]         left_chan,
   input  logic [WIDTH-1:0]         right_chan,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_left,
   output logic [WIDTH-1:0]         out_right,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     ovf_clr
`ifdef I2S_FIFO_OVF_CNT_EN
   ,
   output logic [7:0]               ovf_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (CAP_DELAY > 1) ? $clog2(CAP_DELAY) : 1;
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

   localparam logic [1:0] S_UNARMED = 2'd0;
   localparam logic [1:0] S_IDLE    = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_PUSH    = 2'd3;

   logic [1:0]         state;
   logic [CW-1:0]      dly;
   logic               ws_q;
   logic               ws_fall;
   logic [AW-1:0]      wptr;
   logic [AW-1:0]      rptr;
   logic [2*WIDTH-1:0] mem [DEPTH];
   logic [2*WIDTH-1:0] head;
   logic               push;
   logic               pop;
   logic               full;
   logic               write_en;
   logic               drop;

   // A 1->0 transition on ws marks the end of the right word of a frame.
   assign ws_fall  = ws_q & ~ws;

   assign push     = (state == S_PUSH);
   assign out_valid = (level != '0);
   assign pop      = out_valid & out_ready;
   assign full     = (level == LVL_FULL);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign write_en = push & (~full | pop);
   assign drop     = push & full & ~pop;

   assign head      = mem[rptr];
   assign out_left  = out_valid ? head[2*WIDTH-1:WIDTH] : '0;
   assign out_right = out_valid ? head[WIDTH-1:0]       : '0;

   // Delay ws by one cycle so a falling edge can be detected.
   always_ff @(posedge sclk) begin
      if (rst) begin
         ws_q <= 1'b0;
      end else begin
         ws_q <= ws;
      end
   end

   // Capture sequencer: arm on the first boundary, then wait CAP_DELAY cycles
   // after each later boundary before pushing; boundaries seen while busy are ignored.
   always_ff @(posedge sclk) begin
      if (rst) begin
         state <= S_UNARMED;
         dly   <= '0;
      end else begin
         case (state)
            S_UNARMED: begin
               if (ws_fall) begin
                  state <= S_IDLE;
               end
            end
            S_IDLE: begin
               if (ws_fall) begin
                  dly   <= CW'(CAP_DELAY - 1);
                  state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (dly == '0) begin
                  state <= S_PUSH;
               end else begin
                  dly <= dly - 1'b1;
               end
            end
            S_PUSH: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_UNARMED;
            end
         endcase
      end
   end

   // Sample storage; contents need no reset because the pointers define validity.
   always_ff @(posedge sclk) begin
      if (!rst && write_en) begin
         mem[wptr] <= {left_chan, right_chan};
      end
   end

   // Pointers and occupancy move together so level never lags push/pop.
   always_ff @(posedge sclk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (write_en) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         case ({write_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Sticky overflow flag; a new drop takes priority over a clear.
   always_ff @(posedge sclk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef I2S_FIFO_OVF_CNT_EN
   // Saturating dropped-frame counter; a clear coinciding with a drop leaves 1.
   always_ff @(posedge sclk) begin
      if (rst) begin
         ovf_count <= '0;
      end else if (ovf_clr) begin
         ovf_count <= drop ? 8'd1 : 8'd0;
      end else if (drop && (ovf_count != 8'hFF)) begin
         ovf_count <= ovf_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_i2s_sample_fifo.sv
// tb_i2s_sample_fifo: directed scenarios plus randomized ws/ready/clear/reset
// traffic, checked every cycle against a timestamp-and-queue reference model.
// Build with I2S_FIFO_OVF_CNT_EN defined to also cover ovf_count.
module tb_i2s_sample_fifo;

   localparam int W         = 16;
   localparam int DEPTH     = 8;
   localparam int CAP_DELAY = 2;

   logic                   sclk = 1'b0;
   logic                   rst;
   logic                   ws;
   logic [W-1:0]           left_chan;
   logic [W-1:0]           right_chan;
   logic                   out_valid;
   logic                   out_ready;
   logic [W-1:0]           out_left;
   logic [W-1:0]           out_right;
   logic [$clog2(DEPTH):0] level;
   logic                   overflow;
   logic                   ovf_clr;
`ifdef I2S_FIFO_OVF_CNT_EN
   logic [7:0]             ovf_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: captured pairs in a queue, capture scheduled by absolute cycle.
   logic [2*W-1:0] mq[$];
   bit             m_wsq     = 1'b0;
   bit             m_armed   = 1'b0;
   int             m_pending = -1;
   int             m_cyc     = 0;
   bit             m_ovf     = 1'b0;
   int             m_cnt     = 0;

   i2s_sample_fifo #(.WIDTH(W), .DEPTH(DEPTH), .CAP_DELAY(CAP_DELAY)) dut (
      .sclk       (sclk),
      .rst        (rst),
      .ws         (ws),
      .left_chan  (left_chan),
      .right_chan (right_chan),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_left   (out_left),
      .out_right  (out_right),
      .level      (level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
`ifdef I2S_FIFO_OVF_CNT_EN
      ,
      .ovf_count  (ovf_count)
`endif
   );

   always #5 sclk = ~sclk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, m_cyc);
      end
   endtask

   // Advance the model across the coming rising edge using the driven inputs.
   task automatic modelStep();
      bit fall, popping, pushing, dropping;
      if (rst) begin
         mq.delete();
         m_wsq     = 1'b0;
         m_armed   = 1'b0;
         m_pending = -1;
         m_ovf     = 1'b0;
         m_cnt     = 0;
      end else begin
         fall     = m_wsq && !ws;
         popping  = (mq.size() != 0) && out_ready;
         pushing  = (m_pending == m_cyc);
         dropping = pushing && (mq.size() == DEPTH) && !popping;
         if (pushing) begin
            m_pending = -1;
         end else if (fall && m_pending < 0) begin
            if (!m_armed) m_armed = 1'b1;
            else          m_pending = m_cyc + CAP_DELAY + 1;
         end
         if (popping) void'(mq.pop_front());
         if (pushing && !dropping) mq.push_back({left_chan, right_chan});
         if (dropping)     m_ovf = 1'b1;
         else if (ovf_clr) m_ovf = 1'b0;
         if (ovf_clr)                      m_cnt = dropping ? 1 : 0;
         else if (dropping && m_cnt < 255) m_cnt++;
         m_wsq = ws;
      end
      m_cyc++;
   endtask

   task automatic compareModel();
      logic [2*W-1:0] hd;
      hd = (mq.size() != 0) ? mq[0] : '0;
      checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      checkOutput("level",     32'(level),     32'(mq.size()));
      checkOutput("out_left",  32'(out_left),  32'(hd[2*W-1:W]));
      checkOutput("out_right", 32'(out_right), 32'(hd[W-1:0]));
      checkOutput("overflow",  32'(overflow),  32'(m_ovf));
`ifdef I2S_FIFO_OVF_CNT_EN
      checkOutput("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
   endtask

   // Drive one cycle of inputs, step the model, then compare at the falling edge.
   task automatic applyStimulus(input logic w, input logic [W-1:0] l, input logic [W-1:0] r,
                                input logic rdy, input logic clr, input logic rs);
      ws         = w;
      left_chan  = l;
      right_chan = r;
      out_ready  = rdy;
      ovf_clr    = clr;
      rst        = rs;
      modelStep();
      @(negedge sclk);
      compareModel();
   endtask

   task automatic doReset();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   // One frame: ws high 4 cycles then low 4; the capture lands on the 4th low cycle,
   // where the late values, ready and clear are applied.
   task automatic sendFrame(input logic [W-1:0] l, input logic [W-1:0] r,
                            input logic [W-1:0] late_l, input logic [W-1:0] late_r,
                            input logic rdy_push, input logic clr_push);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, l, r, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, l, r, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, late_l, late_r, rdy_push, clr_push, 1'b0);
   endtask

   initial begin
      int ready_pct;
      logic ws_n;
      logic [W-1:0] drain_exp [8];

      // Reset state and first-frame discard
      doReset();
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_left",  32'(out_left),  32'd0);
      checkOutput("rst_right", 32'(out_right), 32'd0);
      checkOutput("rst_level", 32'(level),     32'd0);
      for (int f = 0; f < 3; f++) sendFrame(16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
      checkOutput("three_frames_level", 32'(level),     32'd2);
      checkOutput("three_frames_left",  32'(out_left),  32'hDEAD);
      checkOutput("three_frames_right", 32'(out_right), 32'hBEEF);

      // Capture timing: the value present on the push cycle is the one stored
      doReset();
      sendFrame(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      sendFrame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b0, 1'b0);
      checkOutput("latency_valid", 32'(out_valid), 32'd1);
      checkOutput("latency_left",  32'(out_left),  32'h3333);
      checkOutput("latency_right", 32'(out_right), 32'h4444);

      // Fill past full, then full+pop, then clear colliding with a drop
      doReset();
      sendFrame(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++)
         sendFrame(W'(k), W'(k + 100), W'(k), W'(k + 100), 1'b0, 1'b0);
      checkOutput("full_level",    32'(level),    32'd8);
      checkOutput("full_overflow", 32'(overflow), 32'd1);
      checkOutput("full_head",     32'(out_left), 32'd1);
`ifdef I2S_FIFO_OVF_CNT_EN
      checkOutput("full_ovf_count", 32'(ovf_count), 32'd2);
`endif
      applyStimulus(1'b1, '0, '0, 1'b0, 1'b1, 1'b0);
      checkOutput("clr_overflow", 32'(overflow), 32'd0);
      sendFrame(16'd11, 16'd111, 16'd11, 16'd111, 1'b1, 1'b0);
      checkOutput("pushpop_level",    32'(level),    32'd8);
      checkOutput("pushpop_overflow", 32'(overflow), 32'd0);
      checkOutput("pushpop_head",     32'(out_left), 32'd2);
      sendFrame(16'd12, 16'd112, 16'd12, 16'd112, 1'b0, 1'b1);
      checkOutput("clr_drop_overflow", 32'(overflow), 32'd1);
      checkOutput("clr_drop_level",    32'(level),    32'd8);
`ifdef I2S_FIFO_OVF_CNT_EN
      checkOutput("clr_drop_ovf_count", 32'(ovf_count), 32'd1);
`endif
      drain_exp = '{16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd11};
      for (int i = 0; i < 8; i++) begin
         checkOutput("drain_left", 32'(out_left), 32'(drain_exp[i]));
         applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
      end
      checkOutput("drain_empty", 32'(out_valid), 32'd0);

      // Reset in the middle of a capture wait
      doReset();
      sendFrame(16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
      for (int k = 1; k <= 3; k++) sendFrame(W'(k), W'(k), W'(k), W'(k), 1'b0, 1'b0);
      checkOutput("pre_abort_level", 32'(level), 32'd3);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h55, 16'h55, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h55, 16'h55, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h55, 16'h55, 1'b0, 1'b0, 1'b1);
      checkOutput("abort_level", 32'(level),     32'd0);
      checkOutput("abort_valid", 32'(out_valid), 32'd0);
      sendFrame(16'h77, 16'h77, 16'h77, 16'h77, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'h77, 16'h77, 1'b0, 1'b0, 1'b0);
      checkOutput("rearm_no_push", 32'(level), 32'd0);

      // Randomized traffic with varying consumer back-pressure
      ws_n = 1'b0;
      ready_pct = 50;
      for (int i = 0; i < 4000; i++) begin
         if (i % 500 == 0) ready_pct = $urandom_range(0, 3) * 30;
         if ($urandom_range(0, 3) == 0) ws_n = ~ws_n;
         applyStimulus(ws_n, W'($urandom), W'($urandom),
                       ($urandom_range(0, 99) < ready_pct),
                       ($urandom_range(0, 40) == 0),
                       ($urandom_range(0, 700) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
